// File: rtl/rtc_tick_gen.sv
// Multi-channel programmable tick/toggle generator in the clk_5 domain.
// Each channel divides clk_5 by (D+1); all activity is held off until PLL lock is stable.
`timescale 1ns/1ps
module rtc_tick_gen #(
    parameter int                   NUM_CH      = 4,
    parameter int                   DIV_W       = 16,
    parameter int                   LOCK_WAIT   = 8,
    parameter logic [DIV_W-1:0]     DEFAULT_DIV = '0,
    parameter logic [NUM_CH-1:0]    EN_RESET    = 1,
    localparam int                  CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_5,
    input  logic              RST_N,
    input  logic              pll_locked,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic              ready,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] toggle
);

    localparam int             LW_W   = $clog2(LOCK_WAIT + 1);
    localparam logic [LW_W-1:0] LW_MAX = LW_W'(LOCK_WAIT);

    logic            sync1_reg;
    logic            lock_s_reg;
    logic [LW_W-1:0] lock_cnt_reg;
    logic [LW_W-1:0] lock_cnt_next;

    // pll_locked is asynchronous to clk_5, so it passes a 2-FF synchroniser first
    always_ff @(posedge clk_5 or negedge RST_N) begin
        if (!RST_N) begin
            sync1_reg    <= 1'b0;
            lock_s_reg   <= 1'b0;
            lock_cnt_reg <= '0;
        end else begin
            sync1_reg    <= pll_locked;
            lock_s_reg   <= sync1_reg;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    always_comb begin
        lock_cnt_next = '0;
        if (lock_s_reg) begin
            lock_cnt_next = (lock_cnt_reg < LW_MAX) ? lock_cnt_reg + 1'b1 : lock_cnt_reg;
        end
    end

    assign ready = (lock_cnt_reg == LW_MAX);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             wr_hit;
            logic [DIV_W-1:0] div_reg;
            logic [DIV_W-1:0] div_next;
            logic [DIV_W-1:0] cnt_reg;
            logic [DIV_W-1:0] cnt_next;
            logic             en_reg;
            logic             en_next;
            logic             tick_reg;
            logic             tick_next;
            logic             toggle_reg;
            logic             toggle_next;

            // Out-of-range channel numbers never match, so such writes are dropped
            assign wr_hit = cfg_we && (cfg_ch == CH_W'(gi));

            always_comb begin
                div_next    = div_reg;
                en_next     = en_reg;
                cnt_next    = cnt_reg + 1'b1;
                tick_next   = 1'b0;
                toggle_next = toggle_reg;
                if (wr_hit) begin
                    // A write restarts the period and swallows a coincident terminal count
                    div_next = cfg_div;
                    en_next  = cfg_en;
                    cnt_next = '0;
                end else if (!ready) begin
                    cnt_next    = '0;
                    toggle_next = 1'b0;
                end else if (!en_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == div_reg) begin
                    cnt_next    = '0;
                    tick_next   = 1'b1;
                    toggle_next = ~toggle_reg;
                end
            end

            always_ff @(posedge clk_5 or negedge RST_N) begin
                if (!RST_N) begin
                    div_reg    <= DEFAULT_DIV;
                    en_reg     <= EN_RESET[gi];
                    cnt_reg    <= '0;
                    tick_reg   <= 1'b0;
                    toggle_reg <= 1'b0;
                end else begin
                    div_reg    <= div_next;
                    en_reg     <= en_next;
                    cnt_reg    <= cnt_next;
                    tick_reg   <= tick_next;
                    toggle_reg <= toggle_next;
                end
            end

            assign tick[gi]   = tick_reg;
            assign toggle[gi] = toggle_reg;
        end
    endgenerate

endmodule

// File: tb/tb_rtc_tick_gen.sv
// Directed bench for rtc_tick_gen: lock qualification, division, reprogramming,
// lock loss, disable, out-of-range writes and asynchronous reset.
`timescale 1ns/1ps
module tb_rtc_tick_gen;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;
    localparam int CH_W   = 2;

    logic              clk_5      = 1'b0;
    logic              RST_N      = 1'b0;
    logic              pll_locked = 1'b1;
    logic              cfg_we     = 1'b0;
    logic [CH_W-1:0]   cfg_ch     = '0;
    logic [DIV_W-1:0]  cfg_div    = '0;
    logic              cfg_en     = 1'b0;
    logic              ready;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] toggle;

    logic              b_cfg_we  = 1'b0;
    logic [1:0]        b_cfg_ch  = '0;
    logic [DIV_W-1:0]  b_cfg_div = '0;
    logic              b_cfg_en  = 1'b0;
    logic              b_ready;
    logic [2:0]        b_tick;
    logic [2:0]        b_toggle;

    logic [3:0]        et;
    logic [3:0]        eg;
    int                n_vec = 0;
    int                n_err = 0;

    rtc_tick_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_WAIT(8)) u_dut (
        .clk_5(clk_5), .RST_N(RST_N), .pll_locked(pll_locked),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
        .ready(ready), .tick(tick), .toggle(toggle)
    );

    // Three-channel instance so that an unrepresentable-on-4 channel number (3) is out of range
    rtc_tick_gen #(.NUM_CH(3), .DIV_W(DIV_W), .LOCK_WAIT(8)) u_dut3 (
        .clk_5(clk_5), .RST_N(RST_N), .pll_locked(pll_locked),
        .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch), .cfg_div(b_cfg_div), .cfg_en(b_cfg_en),
        .ready(b_ready), .tick(b_tick), .toggle(b_toggle)
    );

    always #100 clk_5 = ~clk_5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cfg_write(input int ch, input int dv, input logic en);
        cfg_ch  = CH_W'(ch);
        cfg_div = DIV_W'(dv);
        cfg_en  = en;
        cfg_we  = 1'b1;
        @(negedge clk_5);
        cfg_we  = 1'b0;
        $display("write ch%0d D=%0d en=%0b", ch, dv, en);
    endtask

    // Expected outputs j edges after ready, all channels enabled with D = {1,2,4,0} (ch3..ch0)
    function automatic void exp_run(input int j, output logic [3:0] t, output logic [3:0] g);
        int dv;
        for (int i = 0; i < 4; i++) begin
            dv   = (i == 0) ? 0 : (i == 1) ? 4 : (i == 2) ? 2 : 1;
            t[i] = ((j % (dv + 1)) == 0);
            g[i] = (((j / (dv + 1)) % 2) == 1);
        end
    endfunction

    initial begin
        repeat (3) @(negedge clk_5);
        check("rst_ready", ready, 0);
        check("rst_tick", tick, 0);
        check("rst_toggle", toggle, 0);

        RST_N = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_5);
            check("lock_ready", ready, k == 10);
            check("lock_tick", tick, 0);
        end
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk_5);
            check("ch0_tick", tick, 4'b0001);
            check("ch0_toggle", toggle, {3'b000, j[0]});
        end

        cfg_write(1, 4, 1'b1);
        check("wr_tick1", tick[1], 0);
        check("wr_toggle1", toggle[1], 0);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk_5);
            check("div5_tick", tick[1], (j % 5) == 0);
            check("div5_toggle", toggle[1], (j / 5) % 2);
        end

        // ch1 now at cnt=2: reprogram to D=9
        cfg_write(1, 9, 1'b1);
        check("rep_tick", tick[1], 0);
        check("rep_toggle", toggle[1], 0);
        for (int j = 1; j <= 19; j++) begin
            @(negedge clk_5);
            check("div10_tick", tick[1], j == 10);
            check("div10_toggle", toggle[1], j >= 10);
        end

        // ch1 now at cnt==D: the write drops this terminal count
        cfg_write(1, 4, 1'b1);
        check("coin_tick", tick[1], 0);
        check("coin_toggle", toggle[1], 1);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk_5);
            check("post_coin_tick", tick[1], j == 5);
            check("post_coin_toggle", toggle[1], j < 5);
        end

        cfg_write(2, 2, 1'b1);
        cfg_write(3, 1, 1'b1);

        pll_locked = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_5);
            check("loss_ready", ready, k < 3);
            if (k >= 4) begin
                check("loss_tick", tick, 0);
                check("loss_toggle", toggle, 0);
            end
        end
        pll_locked = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_5);
            check("relock_ready", ready, k == 10);
            check("relock_tick", tick, 0);
        end
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk_5);
            exp_run(j, et, eg);
            check("run_tick", tick, et);
            check("run_toggle", toggle, eg);
        end

        cfg_write(2, 2, 1'b0);
        check("dis_tick2", tick[2], 0);
        check("dis_toggle2", toggle[2], 1);
        for (int j = 12; j <= 16; j++) begin
            @(negedge clk_5);
            exp_run(j, et, eg);
            check("dis_tick", tick, {et[3], 1'b0, et[1:0]});
            check("dis_toggle", toggle, {eg[3], 1'b1, eg[1:0]});
        end

        b_cfg_ch  = 2'd3;
        b_cfg_div = 16'd0;
        b_cfg_en  = 1'b1;
        b_cfg_we  = 1'b1;
        @(negedge clk_5);
        b_cfg_we  = 1'b0;
        $display("write (3-ch) ch3 D=0 en=1");
        for (int j = 1; j <= 4; j++) begin
            check("oor_tick", b_tick, 3'b001);
            check("oor_toggle_hi", b_toggle[2:1], 0);
            @(negedge clk_5);
        end

        #20 RST_N = 1'b0;
        #1;
        check("arst_ready", ready, 0);
        check("arst_tick", tick, 0);
        check("arst_toggle", toggle, 0);
        check("arst_b_tick", b_tick, 0);
        @(negedge clk_5);
        RST_N = 1'b1;
        for (int k = 1; k <= 10; k++) @(negedge clk_5);
        check("arst_relock", ready, 1);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk_5);
            check("arst_cfg_tick", tick, 4'b0001);
            check("arst_cfg_toggle", toggle, {3'b000, j[0]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
